// File: rtl/scm_read_port_arbiter_pkg.sv
// rtl/scm_read_port_arbiter_pkg.sv - shared index helpers for the SCM read-port arbiter
package scm_arb_pkg;

    // Master index width; a single master still needs one bit to hold index 0.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/scm_read_port_arbiter_if.sv
// rtl/scm_read_port_arbiter_if.sv - requester-side req/gnt/rvalid bundle of the read-port arbiter
interface scm_read_port_arbiter_if #(
    parameter int N_MASTER   = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic [N_MASTER-1:0]                 req_i;
    logic [N_MASTER-1:0][ADDR_WIDTH-1:0] addr_i;
    logic [N_MASTER-1:0]                 gnt_o;
    logic [N_MASTER-1:0]                 rvalid_o;
    logic [N_MASTER-1:0][DATA_WIDTH-1:0] rdata_o;

    modport master (output req_i, addr_i, input gnt_o, rvalid_o, rdata_o);
    modport slave  (input req_i, addr_i, output gnt_o, rvalid_o, rdata_o);
endinterface

// File: rtl/scm_read_port_arbiter_rr.sv
// rtl/scm_read_port_arbiter_rr.sv - combinational rotating-priority N_MASTER to N_READ selector
module scm_rr_multi_grant
    import scm_arb_pkg::*;
#(
    parameter int N_MASTER  = 4,
    parameter int N_READ    = 2,
    parameter int MST_IDX_W = idx_width(N_MASTER)
) (
    input  logic [N_MASTER-1:0]              req,
    input  logic [MST_IDX_W-1:0]             prio,
    output logic [N_MASTER-1:0]              gnt,
    output logic [N_READ-1:0][MST_IDX_W-1:0] port_idx,
    output logic [N_READ-1:0]                port_vld,
    output logic [MST_IDX_W-1:0]             last_idx,
    output logic                             any_gnt
);
    logic [MST_IDX_W-1:0] cur;
    int                   cnt;

    // The k-th requester met while walking the ring from prio lands on port k.
    always_comb begin
        gnt      = '0;
        port_idx = '0;
        port_vld = '0;
        last_idx = prio;
        cur      = prio;
        cnt      = 0;
        for (int i = 0; i < N_MASTER; i++) begin
            if (req[cur] && cnt < N_READ) begin
                gnt[cur] = 1'b1;
                for (int p = 0; p < N_READ; p++) begin
                    if (p == cnt) begin
                        port_idx[p] = cur;
                        port_vld[p] = 1'b1;
                    end
                end
                last_idx = cur;
                cnt      = cnt + 1;
            end
            cur = MST_IDX_W'(rr_next(32'(cur), N_MASTER));
        end
        any_gnt = |gnt;
    end

endmodule

// File: rtl/scm_read_port_arbiter.sv
// rtl/scm_read_port_arbiter.sv - round-robin sharing of register-file read ports among masters
// Optional write-first forwarding from the snooped write port: SCM_READ_ARB_WR_FWD_EN.
module scm_read_port_arbiter
    import scm_arb_pkg::*;
#(
    parameter int N_MASTER   = 4,
    parameter int N_READ     = 2,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    scm_read_port_arbiter_if.slave              bus,
    output logic [N_READ-1:0]                   ReadEnable_o,
    output logic [N_READ-1:0][ADDR_WIDTH-1:0]   ReadAddr_o,
    input  logic [N_READ-1:0][DATA_WIDTH-1:0]   ReadData_i
`ifdef SCM_READ_ARB_WR_FWD_EN
    ,
    input  logic                                WriteEnable_i,
    input  logic [ADDR_WIDTH-1:0]               WriteAddr_i,
    input  logic [DATA_WIDTH-1:0]               WriteData_i
`endif
);
    localparam int MST_IDX_W = idx_width(N_MASTER);

    logic [MST_IDX_W-1:0]             prio_q, prio_d;
    logic [N_READ-1:0]                valid_q, valid_d;
    logic [N_READ-1:0][MST_IDX_W-1:0] tag_q, tag_d;

    logic [N_MASTER-1:0]              req_eff, gnt;
    logic [N_READ-1:0][MST_IDX_W-1:0] port_idx;
    logic [N_READ-1:0]                port_vld;
    logic [MST_IDX_W-1:0]             last_idx;
    logic                             any_gnt;
    logic [N_READ-1:0][DATA_WIDTH-1:0] resp_data;
    logic [N_MASTER-1:0]              rvalid;
    logic [N_MASTER-1:0][DATA_WIDTH-1:0] rdata;

    // Masking requests during reset keeps gnt and ReadEnable low without extra gating.
    assign req_eff = rst ? '0 : bus.req_i;

    scm_rr_multi_grant #(
        .N_MASTER  (N_MASTER),
        .N_READ    (N_READ),
        .MST_IDX_W (MST_IDX_W)
    ) u_sel (
        .req      (req_eff),
        .prio     (prio_q),
        .gnt      (gnt),
        .port_idx (port_idx),
        .port_vld (port_vld),
        .last_idx (last_idx),
        .any_gnt  (any_gnt)
    );

    always_comb begin
        ReadEnable_o = port_vld;
        for (int p = 0; p < N_READ; p++) begin
            ReadAddr_o[p] = port_vld[p] ? bus.addr_i[port_idx[p]] : '0;
        end
    end

    always_comb begin
        prio_d  = any_gnt ? MST_IDX_W'(rr_next(32'(last_idx), N_MASTER)) : prio_q;
        valid_d = port_vld;
        tag_d   = port_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q  <= '0;
            valid_q <= '0;
            tag_q   <= '0;
        end else begin
            prio_q  <= prio_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

`ifdef SCM_READ_ARB_WR_FWD_EN
    logic [N_READ-1:0]                 fwd_q, fwd_d;
    logic [N_READ-1:0][DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;

    // A write landing on an address being read this cycle wins over the stale array data.
    always_comb begin
        for (int p = 0; p < N_READ; p++) begin
            fwd_d[p]      = WriteEnable_i && port_vld[p] && (WriteAddr_i == ReadAddr_o[p]);
            fwd_data_d[p] = fwd_d[p] ? WriteData_i : fwd_data_q[p];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_q      <= '0;
            fwd_data_q <= '0;
        end else begin
            fwd_q      <= fwd_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    always_comb begin
        for (int p = 0; p < N_READ; p++) begin
            resp_data[p] = fwd_q[p] ? fwd_data_q[p] : ReadData_i[p];
        end
    end
`else
    assign resp_data = ReadData_i;
`endif

    always_comb begin
        rvalid = '0;
        rdata  = '0;
        for (int p = 0; p < N_READ; p++) begin
            if (valid_q[p] && !rst) begin
                rvalid[tag_q[p]] = 1'b1;
                rdata[tag_q[p]]  = resp_data[p];
            end
        end
    end

    assign bus.gnt_o    = gnt;
    assign bus.rvalid_o = rvalid;
    assign bus.rdata_o  = rdata;

endmodule

// File: tb/tb_scm_read_port_arbiter.sv
// tb/tb_scm_read_port_arbiter.sv - self-checking bench for scm_read_port_arbiter
module tb_scm_read_port_arbiter;
    localparam int N  = 4;
    localparam int NR = 2;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int FAIR = (N + NR - 1) / NR;
`ifdef SCM_READ_ARB_WR_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic [NR-1:0]          re;
    logic [NR-1:0][AW-1:0]  raddr;
    logic [NR-1:0][DW-1:0]  rd;
    logic                   we;
    logic [AW-1:0]          wa;
    logic [DW-1:0]          wd;
    logic [DW-1:0]          mem [32];

    scm_read_port_arbiter_if #(.N_MASTER(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    scm_read_port_arbiter #(.N_MASTER(N), .N_READ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .ReadEnable_o (re),
        .ReadAddr_o   (raddr),
        .ReadData_i   (rd)
`ifdef SCM_READ_ARB_WR_FWD_EN
        ,
        .WriteEnable_i (we),
        .WriteAddr_i   (wa),
        .WriteData_i   (wd)
`endif
    );

    // Register file: one-cycle read latency, read-old on a same-cycle collision.
    always @(posedge clk) begin
        for (int p = 0; p < NR; p++) if (re[p]) rd[p] <= mem[raddr[p]];
        if (we) mem[wa] <= wd;
    end

    int n_checks = 0;
    int n_errors = 0;

    int                    m_prio;
    logic [N-1:0]          pend_v;
    logic [N-1:0][DW-1:0]  pend_d;
    logic [N-1:0]          exp_gnt, exp_rvalid;
    logic [NR-1:0]         exp_re;
    logic [NR-1:0][AW-1:0] exp_raddr;
    logic [N-1:0][DW-1:0]  exp_rdata;
    int                    wait_cnt [N];

    // Reference: rank requesters by ring distance from the priority pointer, first NR win.
    task automatic model_eval();
        int k;
        int m;
        exp_gnt = '0; exp_re = '0; exp_raddr = '0; k = 0;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                m = (m_prio + i) % N;
                if (bus.req_i[m] && k < NR) begin
                    exp_gnt[m] = 1'b1; exp_re[k] = 1'b1; exp_raddr[k] = bus.addr_i[m]; k++;
                end
            end
        end
        exp_rvalid = rst ? '0 : pend_v;
        exp_rdata  = rst ? '0 : pend_d;
    endtask

    task automatic model_commit();
        int m;
        int last;
        pend_v = '0; pend_d = '0; last = -1;
        if (rst) begin
            m_prio = 0;
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            m = (m_prio + i) % N;
            if (exp_gnt[m]) begin
                pend_v[m] = 1'b1;
                pend_d[m] = (FWD && we && wa == bus.addr_i[m]) ? wd : mem[bus.addr_i[m]];
                last = m;
            end
        end
        if (last >= 0) m_prio = (last + 1) % N;
        for (int i = 0; i < N; i++) wait_cnt[i] = (bus.req_i[i] && !exp_gnt[i]) ? wait_cnt[i] + 1 : 0;
    endtask

    task automatic sample();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.req_i = '0; we = 1'b0;
        sample(); advance();
        rst = 1'b0;
    endtask

    task automatic write_rf(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_i = '0; we = 1'b1; wa = a; wd = d;
        sample(); advance();
        we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.req_i = '1; bus.addr_i = '0;
        for (int a = 0; a < 32; a++) begin
            we = 1'b1; wa = AW'(a); wd = $urandom;
            sample();
            n_checks++; if (bus.gnt_o !== '0) begin n_errors++; $display("FAIL reset_gnt: got %b want 0", bus.gnt_o); end
            n_checks++; if (re !== '0) begin n_errors++; $display("FAIL reset_re: got %b want 0", re); end
            n_checks++; if (bus.rvalid_o !== '0 || bus.rdata_o !== '0) begin n_errors++; $display("FAIL reset_rvalid: got %b/%h want 0", bus.rvalid_o, bus.rdata_o); end
            advance();
        end
        we = 1'b0; bus.req_i = '0; rst = 1'b0;
    endtask

    task automatic test_single();
        write_rf(5'h0A, 32'hDEADBEEF);
        bus.req_i = 4'b0010; bus.addr_i[1] = 5'h0A;
        sample();
        n_checks++; if (bus.gnt_o !== 4'b0010) begin n_errors++; $display("FAIL single_gnt: got %b want 0010", bus.gnt_o); end
        n_checks++; if (re !== 2'b01 || raddr[0] !== 5'h0A || raddr[1] !== 5'h00) begin n_errors++; $display("FAIL single_port: got re=%b addr=%h want re=01 addr=000a", re, raddr); end
        advance();
        bus.req_i = 4'b1111;
        sample();
        n_checks++; if (bus.rvalid_o !== 4'b0010) begin n_errors++; $display("FAIL single_rvalid: got %b want 0010", bus.rvalid_o); end
        n_checks++; if (bus.rdata_o[1] !== 32'hDEADBEEF) begin n_errors++; $display("FAIL single_rdata: got %h want deadbeef", bus.rdata_o[1]); end
        n_checks++; if (bus.gnt_o !== 4'b1100) begin n_errors++; $display("FAIL single_prio: got %b want 1100", bus.gnt_o); end
        advance();
        bus.req_i = '0; sample(); advance();
    endtask

    task automatic test_all_continuous();
        logic [N-1:0] want;
        do_reset();
        for (int m = 0; m < N; m++) bus.addr_i[m] = AW'(m * 7 + 1);
        bus.req_i = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            sample();
            want = (c % 2 == 0) ? 4'b0011 : 4'b1100;
            n_checks++; if (bus.gnt_o !== want) begin n_errors++; $display("FAIL all_gnt c%0d: got %b want %b", c, bus.gnt_o, want); end
            if (c > 0) begin
                n_checks++; if (bus.rvalid_o !== ~want) begin n_errors++; $display("FAIL all_rvalid c%0d: got %b want %b", c, bus.rvalid_o, ~want); end
                n_checks++; if (bus.rdata_o !== exp_rdata) begin n_errors++; $display("FAIL all_rdata c%0d: got %h want %h", c, bus.rdata_o, exp_rdata); end
            end
            advance();
        end
        bus.req_i = '0; sample(); advance();
    endtask

    task automatic test_wrap();
        do_reset();
        bus.req_i = 4'b0100; bus.addr_i[2] = 5'h02;
        sample(); advance();
        bus.req_i = 4'b1001; bus.addr_i[3] = 5'h11; bus.addr_i[0] = 5'h05;
        sample();
        n_checks++; if (bus.gnt_o !== 4'b1001) begin n_errors++; $display("FAIL wrap_gnt: got %b want 1001", bus.gnt_o); end
        n_checks++; if (raddr[0] !== 5'h11 || raddr[1] !== 5'h05) begin n_errors++; $display("FAIL wrap_ports: got %h want 11/05", raddr); end
        advance();
        bus.req_i = 4'b1111;
        sample();
        n_checks++; if (bus.gnt_o !== 4'b0110) begin n_errors++; $display("FAIL wrap_prio: got %b want 0110", bus.gnt_o); end
        n_checks++; if (bus.rvalid_o !== 4'b1001 || bus.rdata_o !== exp_rdata) begin n_errors++; $display("FAIL wrap_resp: got %b/%h want 1001/%h", bus.rvalid_o, bus.rdata_o, exp_rdata); end
        advance();
        bus.req_i = '0; sample(); advance();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        bus.req_i = 4'b0001; bus.addr_i[0] = 5'h04;
        sample();
        n_checks++; if (bus.gnt_o !== 4'b0001) begin n_errors++; $display("FAIL mid_gnt: got %b want 0001", bus.gnt_o); end
        advance();
        rst = 1'b1; bus.req_i = '0;
        sample();
        n_checks++; if (bus.rvalid_o !== '0 || bus.rdata_o !== '0) begin n_errors++; $display("FAIL mid_rvalid_n1: got %b/%h want 0", bus.rvalid_o, bus.rdata_o); end
        advance();
        rst = 1'b0;
        sample();
        n_checks++; if (bus.rvalid_o !== '0) begin n_errors++; $display("FAIL mid_rvalid_n2: got %b want 0", bus.rvalid_o); end
        advance();
        bus.req_i = 4'b1111;
        sample();
        n_checks++; if (bus.gnt_o !== 4'b0011) begin n_errors++; $display("FAIL mid_prio: got %b want 0011", bus.gnt_o); end
        advance();
        bus.req_i = '0; sample(); advance();
    endtask

    task automatic test_same_addr();
        write_rf(5'h1F, 32'h1234);
        bus.req_i = 4'b0101; bus.addr_i[0] = 5'h1F; bus.addr_i[2] = 5'h1F;
        sample();
        n_checks++; if (bus.gnt_o !== 4'b0101 || raddr[0] !== 5'h1F || raddr[1] !== 5'h1F) begin n_errors++; $display("FAIL same_gnt: got %b/%h want 0101/1f1f", bus.gnt_o, raddr); end
        advance();
        bus.req_i = '0;
        sample();
        n_checks++; if (bus.rvalid_o !== 4'b0101 || bus.rdata_o[0] !== 32'h1234 || bus.rdata_o[2] !== 32'h1234) begin n_errors++; $display("FAIL same_data: got %b/%h want 0101 with 1234", bus.rvalid_o, bus.rdata_o); end
        advance();
    endtask

    task automatic test_write_collision();
        logic [DW-1:0] want;
        write_rf(5'h03, 32'h0);
        bus.req_i = 4'b0010; bus.addr_i[1] = 5'h03;
        we = 1'b1; wa = 5'h03; wd = 32'hCAFEF00D;
        sample(); advance();
        bus.req_i = '0; we = 1'b0;
        sample();
        want = FWD ? 32'hCAFEF00D : 32'h0;
        n_checks++; if (bus.rvalid_o !== 4'b0010 || bus.rdata_o[1] !== want) begin n_errors++; $display("FAIL collision: got %b/%h want 0010/%h", bus.rvalid_o, bus.rdata_o[1], want); end
        advance();
    endtask

    task automatic test_random();
        do_reset();
        bus.req_i = '0; exp_gnt = '0;
        for (int c = 0; c < 400; c++) begin
            for (int m = 0; m < N; m++) begin
                if (!bus.req_i[m] || exp_gnt[m]) begin
                    bus.req_i[m] = ($urandom_range(0, 3) != 0);
                    bus.addr_i[m] = AW'($urandom_range(0, 7));
                end
            end
            we = ($urandom_range(0, 3) == 0); wa = AW'($urandom_range(0, 7)); wd = $urandom;
            sample();
            n_checks++; if (bus.gnt_o !== exp_gnt) begin n_errors++; $display("FAIL rand_gnt c%0d: got %b want %b", c, bus.gnt_o, exp_gnt); end
            n_checks++; if (re !== exp_re || raddr !== exp_raddr) begin n_errors++; $display("FAIL rand_port c%0d: got %b/%h want %b/%h", c, re, raddr, exp_re, exp_raddr); end
            n_checks++; if (bus.rvalid_o !== exp_rvalid) begin n_errors++; $display("FAIL rand_rvalid c%0d: got %b want %b", c, bus.rvalid_o, exp_rvalid); end
            n_checks++; if (bus.rdata_o !== exp_rdata) begin n_errors++; $display("FAIL rand_rdata c%0d: got %h want %h", c, bus.rdata_o, exp_rdata); end
            for (int m = 0; m < N; m++) begin
                if (bus.req_i[m] && wait_cnt[m] >= FAIR - 1) begin
                    n_checks++; if (bus.gnt_o[m] !== 1'b1) begin n_errors++; $display("FAIL fairness c%0d m%0d: waited %0d got gnt %b", c, m, wait_cnt[m], bus.gnt_o[m]); end
                end
            end
            advance();
        end
        bus.req_i = '0; we = 1'b0; sample(); advance();
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0;
        bus.req_i = '0; bus.addr_i = '0;
        m_prio = 0; pend_v = '0; pend_d = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_all_continuous();
        test_wrap();
        test_reset_midflight();
        test_same_addr();
        test_write_collision();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
